// File: rtl/csr_file_intr.sv
// csr_file_intr: LoongArch CSR file with interrupt sampling, exception entry/return
// state and an optional countdown timer.
// Optional feature macro: CSR_TIMER_EN (TID, TCFG, TVAL, TICLR and ESTAT.IS[11]).
module csr_file_intr #(
    parameter int unsigned SAVE_NUM   = 4,
    parameter int unsigned TIMER_W    = 32,
    parameter int unsigned HW_INT_NUM = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  csr_re,
    input  logic [13:0]           csr_rnum,
    output logic [31:0]           csr_rdata,
    input  logic                  csr_we,
    input  logic [13:0]           csr_wnum,
    input  logic [31:0]           csr_wmask,
    input  logic [31:0]           csr_wdata,
    input  logic                  ertn_flush,
    input  logic                  wb_ex,
    input  logic [5:0]            wb_ecode,
    input  logic [8:0]            wb_esubcode,
    input  logic [31:0]           wb_pc,
    input  logic [31:0]           wb_vaddr,
    input  logic [HW_INT_NUM-1:0] hw_int_in,
    input  logic                  ipi_int_in,
    output logic                  has_int,
    output logic [31:0]           ex_entry,
    output logic [31:0]           era_out,
    output logic [1:0]            crmd_plv
);

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam int unsigned SAVE_BASE  = 32'h30;
    localparam logic [12:0] LIE_MASK   = 13'h1BFF;
    localparam logic [5:0]  ECODE_ADE  = 6'h08;
    localparam logic [5:0]  ECODE_ALE  = 6'h09;

    // Reject out-of-range configurations at elaboration
    if (SAVE_NUM < 1 || SAVE_NUM > 16 || TIMER_W < 8 || TIMER_W > 32 ||
        HW_INT_NUM < 1 || HW_INT_NUM > 8) begin : g_bad_param
        $error("csr_file_intr: parameter out of range");
    end

    // Masked write merge: bits with mask=1 take new data, others keep old value
    function automatic logic [31:0] f_merge(input logic [31:0] old,
                                            input logic [31:0] mask,
                                            input logic [31:0] data);
        return (mask & data) | (~mask & old);
    endfunction

    logic [8:0]            r_crmd;       // {DATM, DATF, PG, DA, IE, PLV}
    logic [2:0]            r_prmd;       // {PIE, PPLV}
    logic [12:0]           r_ecfg_lie;
    logic [1:0]            r_is_sw;
    logic [HW_INT_NUM-1:0] r_is_hw;
    logic                  r_is_ipi;
    logic [5:0]            r_ecode;
    logic [8:0]            r_esubcode;
    logic [31:0]           r_era;
    logic [31:0]           r_badv;
    logic [25:0]           r_eentry_va;
    logic [31:0]           r_save [SAVE_NUM];
    logic                  r_has_int;
    logic                  w_ti;
    logic [12:0]           w_is;
    logic [31:0]           w_rdata;
    logic                  w_wr_crmd, w_wr_prmd, w_wr_ecfg, w_wr_estat;
    logic                  w_wr_era, w_wr_badv, w_wr_eentry;

    assign w_wr_crmd   = csr_we && (csr_wnum == CSR_CRMD);
    assign w_wr_prmd   = csr_we && (csr_wnum == CSR_PRMD);
    assign w_wr_ecfg   = csr_we && (csr_wnum == CSR_ECFG);
    assign w_wr_estat  = csr_we && (csr_wnum == CSR_ESTAT);
    assign w_wr_era    = csr_we && (csr_wnum == CSR_ERA);
    assign w_wr_badv   = csr_we && (csr_wnum == CSR_BADV);
    assign w_wr_eentry = csr_we && (csr_wnum == CSR_EENTRY);

    assign w_is = {r_is_ipi, w_ti, 1'b0, 8'(r_is_hw), r_is_sw};

`ifdef CSR_TIMER_EN
    localparam logic [13:0]        CSR_TID   = 14'h040;
    localparam logic [13:0]        CSR_TCFG  = 14'h041;
    localparam logic [13:0]        CSR_TVAL  = 14'h042;
    localparam logic [13:0]        CSR_TICLR = 14'h044;
    localparam logic [TIMER_W-1:0] CNT_ONES  = '1;

    logic [31:0]        r_tid;
    logic [TIMER_W-1:0] r_tcfg;      // {InitVal, Periodic, En}
    logic [TIMER_W-1:0] r_cnt;
    logic               r_ti;
    logic [TIMER_W-1:0] w_tcfg_new;
    logic               w_wr_tcfg, w_ticlr, w_expire;

    assign w_wr_tcfg  = csr_we && (csr_wnum == CSR_TCFG);
    assign w_tcfg_new = TIMER_W'(f_merge(32'(r_tcfg), csr_wmask, csr_wdata));
    assign w_ticlr    = csr_we && (csr_wnum == CSR_TICLR) && csr_wmask[0] && csr_wdata[0];
    // A TCFG write owns the counter for that cycle, so it also suppresses expiry
    assign w_expire   = r_tcfg[0] && (r_cnt == '0) && !w_wr_tcfg;
    assign w_ti       = r_ti;

    // TID and TCFG registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tid  <= 32'h0;
            r_tcfg <= '0;
        end else begin
            if (csr_we && (csr_wnum == CSR_TID)) r_tid <= f_merge(r_tid, csr_wmask, csr_wdata);
            if (w_wr_tcfg) r_tcfg <= w_tcfg_new;
        end
    end

    // Countdown: load on enabling write, reload or run out to all-ones on expiry
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= CNT_ONES;
        end else if (w_wr_tcfg) begin
            if (w_tcfg_new[0]) r_cnt <= {w_tcfg_new[TIMER_W-1:2], 2'b00};
        end else if (r_tcfg[0] && (r_cnt != CNT_ONES)) begin
            if ((r_cnt == '0) && r_tcfg[1]) r_cnt <= {r_tcfg[TIMER_W-1:2], 2'b00};
            else                            r_cnt <= r_cnt - TIMER_W'(1);
        end
    end

    // Timer interrupt flag: expiry set beats a same-cycle TICLR clear
    always_ff @(posedge clk) begin
        if (reset)         r_ti <= 1'b0;
        else if (w_expire) r_ti <= 1'b1;
        else if (w_ticlr)  r_ti <= 1'b0;
    end
`else
    assign w_ti = 1'b0;
`endif

    // CRMD: exception entry clears PLV/IE, ERTN restores them from PRMD
    always_ff @(posedge clk) begin
        if (reset)           r_crmd <= 9'h008;
        else if (wb_ex)      r_crmd[2:0] <= 3'b000;
        else if (ertn_flush) r_crmd[2:0] <= r_prmd;
        else if (w_wr_crmd)  r_crmd <= 9'(f_merge(32'(r_crmd), csr_wmask, csr_wdata));
    end

    // PRMD: saves {IE, PLV} on exception entry
    always_ff @(posedge clk) begin
        if (reset)          r_prmd <= 3'b000;
        else if (wb_ex)     r_prmd <= r_crmd[2:0];
        else if (w_wr_prmd) r_prmd <= 3'(f_merge(32'(r_prmd), csr_wmask, csr_wdata));
    end

    // ECFG.LIE with bit 10 held at zero
    always_ff @(posedge clk) begin
        if (reset)          r_ecfg_lie <= 13'h0;
        else if (w_wr_ecfg) r_ecfg_lie <= 13'(f_merge(32'(r_ecfg_lie), csr_wmask, csr_wdata)) & LIE_MASK;
    end

    // ESTAT: cause fields on exception, software IS bits, sampled interrupt lines
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ecode    <= 6'h0;
            r_esubcode <= 9'h0;
            r_is_sw    <= 2'b00;
            r_is_hw    <= '0;
            r_is_ipi   <= 1'b0;
        end else begin
            r_is_hw  <= hw_int_in;
            r_is_ipi <= ipi_int_in;
            if (wb_ex) begin
                r_ecode    <= wb_ecode;
                r_esubcode <= wb_esubcode;
            end else if (w_wr_estat) begin
                r_is_sw <= 2'(f_merge(32'(r_is_sw), csr_wmask, csr_wdata));
            end
        end
    end

    // ERA and BADV carry no reset value
    always_ff @(posedge clk) begin
        if (wb_ex)         r_era <= wb_pc;
        else if (w_wr_era) r_era <= f_merge(r_era, csr_wmask, csr_wdata);
        if (wb_ex) begin
            if ((wb_ecode == ECODE_ADE) || (wb_ecode == ECODE_ALE)) r_badv <= wb_vaddr;
        end else if (w_wr_badv) begin
            r_badv <= f_merge(r_badv, csr_wmask, csr_wdata);
        end
    end

    // EENTRY.VA occupies bits 31:6
    always_ff @(posedge clk) begin
        if (reset)            r_eentry_va <= 26'h0;
        else if (w_wr_eentry) r_eentry_va <= 26'(f_merge({r_eentry_va, 6'b0}, csr_wmask, csr_wdata) >> 6);
    end

    // SAVE scratch registers, no reset value
    always_ff @(posedge clk) begin
        for (int i = 0; i < SAVE_NUM; i++) begin
            if (csr_we && (csr_wnum == 14'(SAVE_BASE + 32'(i))))
                r_save[i] <= f_merge(r_save[i], csr_wmask, csr_wdata);
        end
    end

    // Interrupt request, one cycle behind IE/LIE/IS
    always_ff @(posedge clk) begin
        if (reset) r_has_int <= 1'b0;
        else       r_has_int <= r_crmd[2] && (|(r_ecfg_lie & w_is));
    end

    // Read mux; unimplemented numbers fall through to zero
    always_comb begin
        w_rdata = 32'h0;
        case (csr_rnum)
            CSR_CRMD:   w_rdata = 32'(r_crmd);
            CSR_PRMD:   w_rdata = 32'(r_prmd);
            CSR_ECFG:   w_rdata = 32'(r_ecfg_lie);
            CSR_ESTAT:  w_rdata = {1'b0, r_esubcode, r_ecode, 3'b000, w_is};
            CSR_ERA:    w_rdata = r_era;
            CSR_BADV:   w_rdata = r_badv;
            CSR_EENTRY: w_rdata = {r_eentry_va, 6'b0};
`ifdef CSR_TIMER_EN
            CSR_TID:    w_rdata = r_tid;
            CSR_TCFG:   w_rdata = 32'(r_tcfg);
            CSR_TVAL:   w_rdata = 32'(r_cnt);
`endif
            default: begin
                for (int i = 0; i < SAVE_NUM; i++) begin
                    if (csr_rnum == 14'(SAVE_BASE + 32'(i))) w_rdata = r_save[i];
                end
            end
        endcase
    end

    assign csr_rdata = csr_re ? w_rdata : 32'h0;
    assign has_int   = r_has_int;
    assign ex_entry  = {r_eentry_va, 6'b0};
    assign era_out   = r_era;
    assign crmd_plv  = r_crmd[1:0];

endmodule
